// File: rtl/detector_agc_stretch.sv
// detector_agc_stretch: per-frame video statistics plus a 3-stage black-level/gain stretch
// from 14-bit pixels to 8 bits, configured over an Avalon-MM slave.
module detector_agc_stretch #(
    parameter int GAIN_SHIFT = 8,
    parameter int SUM_W      = 40,
    parameter int CNT_W      = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  av_address,
    input  logic        av_read,
    output logic [31:0] av_readdata,
    input  logic        av_write,
    input  logic [31:0] av_writedata,
    input  logic        din_startofpacket,
    input  logic        din_endofpacket,
    input  logic        din_valid,
    input  logic [13:0] din_data,
    output logic        dout_startofpacket,
    output logic        dout_endofpacket,
    output logic        dout_valid,
    output logic [7:0]  dout_data,
    output logic        frame_irq
);
    localparam logic [0:0] S_IDLE = 1'b0, S_IN = 1'b1;

    logic [0:0]       r_state;
    logic [1:0]       r_ctrl;
    logic [13:0]      r_manual_low, r_low;
    logic [15:0]      r_gain;
    logic [13:0]      r_acc_min, r_acc_max, r_res_min, r_res_max;
    logic [SUM_W-1:0] r_acc_sum, r_res_sum;
    logic [CNT_W-1:0] r_acc_cnt, r_res_cnt;
    logic [31:0]      r_frame_cnt;
    logic             r_done;
    logic [13:0]      r_s1_diff;
    logic [15:0]      r_s1_gain;
    logic [29:0]      r_s2_prod;
    logic [7:0]       r_s1_pass, r_s2_pass;
    logic             r_s1_en, r_s2_en;
    logic [2:0]       r_s1_sb, r_s2_sb;

    logic             w_sop, w_acc, w_end;
    logic [13:0]      w_nmin, w_nmax, w_low, w_diff;
    logic [SUM_W-1:0] w_nsum;
    logic [CNT_W-1:0] w_ncnt;
    logic [29:0]      w_scaled;
    logic [31:0]      w_rdata;

    assign w_sop  = din_valid & din_startofpacket;
    assign w_acc  = w_sop | (din_valid & (r_state == S_IN));
    assign w_end  = din_valid & din_endofpacket & (w_sop | (r_state == S_IN));
    assign w_nmin = (w_sop | (din_data < r_acc_min)) ? din_data : r_acc_min;
    assign w_nmax = (w_sop | (din_data > r_acc_max)) ? din_data : r_acc_max;
    assign w_nsum = w_sop ? SUM_W'(din_data) : r_acc_sum + SUM_W'(din_data);
    assign w_ncnt = w_sop ? CNT_W'(1) : (&r_acc_cnt ? r_acc_cnt : r_acc_cnt + 1'b1);
    // Black level is latched at the sop pixel and applies to that pixel too.
    assign w_low    = w_sop ? (r_ctrl[1] ? r_res_min : r_manual_low) : r_low;
    assign w_diff   = (din_data > w_low) ? din_data - w_low : 14'd0;
    assign w_scaled = r_s2_prod >> GAIN_SHIFT;

    always_comb begin
        w_rdata = '0;
        case (av_address)
            3'd0:    w_rdata = {30'd0, r_ctrl};
            3'd1:    w_rdata = {18'd0, r_manual_low};
            3'd2:    w_rdata = {16'd0, r_gain};
            3'd3:    w_rdata = {2'b0, r_res_max, 2'b0, r_res_min};
            3'd4:    w_rdata = r_res_sum[31:0];
            3'd5:    w_rdata = 32'({r_res_sum[SUM_W-1:32], r_res_cnt});
            3'd6:    w_rdata = r_frame_cnt;
            default: w_rdata = {31'd0, r_done};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_ctrl       <= '0;
            r_manual_low <= '0;
            r_gain       <= 16'h0100;
            r_low        <= '0;
            r_acc_min    <= '0;
            r_acc_max    <= '0;
            r_acc_sum    <= '0;
            r_acc_cnt    <= '0;
            r_res_min    <= '0;
            r_res_max    <= '0;
            r_res_sum    <= '0;
            r_res_cnt    <= '0;
            r_frame_cnt  <= '0;
            r_done       <= 1'b0;
            frame_irq    <= 1'b0;
            av_readdata  <= '0;
        end else begin
            av_readdata <= av_read ? w_rdata : 32'd0;
            if (av_write && av_address == 3'd0) r_ctrl <= av_writedata[1:0];
            if (av_write && av_address == 3'd1) r_manual_low <= av_writedata[13:0];
            if (av_write && av_address == 3'd2) r_gain <= av_writedata[15:0];
            if (w_sop) r_low <= w_low;
            if (w_acc) begin
                r_acc_min <= w_nmin;
                r_acc_max <= w_nmax;
                r_acc_sum <= w_nsum;
                r_acc_cnt <= w_ncnt;
            end
            if (w_end) begin
                r_res_min   <= w_nmin;
                r_res_max   <= w_nmax;
                r_res_sum   <= w_nsum;
                r_res_cnt   <= w_ncnt;
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end
            r_state   <= w_end ? S_IDLE : (w_sop ? S_IN : r_state);
            r_done    <= w_end | (r_done & ~(av_write && av_address == 3'd7 && av_writedata[0]));
            frame_irq <= w_end;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_diff          <= '0;
            r_s1_gain          <= '0;
            r_s1_pass          <= '0;
            r_s1_en            <= 1'b0;
            r_s1_sb            <= '0;
            r_s2_prod          <= '0;
            r_s2_pass          <= '0;
            r_s2_en            <= 1'b0;
            r_s2_sb            <= '0;
            dout_data          <= '0;
            dout_startofpacket <= 1'b0;
            dout_endofpacket   <= 1'b0;
            dout_valid         <= 1'b0;
        end else begin
            r_s1_diff <= w_diff;
            r_s1_gain <= r_gain;
            r_s1_pass <= din_data[13:6];
            r_s1_en   <= r_ctrl[0];
            r_s1_sb   <= {din_startofpacket, din_endofpacket, din_valid};
            r_s2_prod <= 30'(r_s1_diff) * 30'(r_s1_gain);
            r_s2_pass <= r_s1_pass;
            r_s2_en   <= r_s1_en;
            r_s2_sb   <= r_s1_sb;
            dout_data <= !r_s2_en ? r_s2_pass : ((w_scaled > 30'd255) ? 8'hFF : w_scaled[7:0]);
            {dout_startofpacket, dout_endofpacket, dout_valid} <= r_s2_sb;
        end
    end
endmodule

// File: tb/tb_detector_agc_stretch.sv
// tb_detector_agc_stretch: table-driven stream vectors plus directed register/corner sequences.
module tb_detector_agc_stretch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  av_address;
    logic        av_read, av_write;
    logic [31:0] av_readdata, av_writedata;
    logic        din_startofpacket, din_endofpacket, din_valid;
    logic [13:0] din_data;
    logic        dout_startofpacket, dout_endofpacket, dout_valid;
    logic [7:0]  dout_data;
    logic        frame_irq;

    int checks = 0;
    int errors = 0;
    int irqs;

    typedef struct {
        logic        sop;
        logic        eop;
        logic        valid;
        logic [13:0] pix;
        logic [7:0]  exp;
    } vec_t;
    vec_t vt[16];

    always #5 clk = ~clk;

    detector_agc_stretch dut (
        .clk(clk), .rst_n(rst_n),
        .av_address(av_address), .av_read(av_read), .av_readdata(av_readdata),
        .av_write(av_write), .av_writedata(av_writedata),
        .din_startofpacket(din_startofpacket), .din_endofpacket(din_endofpacket),
        .din_valid(din_valid), .din_data(din_data),
        .dout_startofpacket(dout_startofpacket), .dout_endofpacket(dout_endofpacket),
        .dout_valid(dout_valid), .dout_data(dout_data), .frame_irq(frame_irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string name);
        av_address = a;
        av_read    = 1'b1;
        tick();
        av_read    = 1'b0;
        chk(name, av_readdata, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        av_address   = a;
        av_writedata = d;
        av_write     = 1'b1;
        tick();
        av_write     = 1'b0;
    endtask

    task automatic pix(input logic s, input logic e, input logic [13:0] p);
        {din_startofpacket, din_endofpacket, din_valid, din_data} = {s, e, 1'b1, p};
        tick();
        {din_startofpacket, din_endofpacket, din_valid, din_data} = '0;
    endtask

    task automatic sv(input int i, input logic s, input logic e, input logic v,
                      input logic [13:0] p, input logic [7:0] x);
        vt[i] = '{s, e, v, p, x};
    endtask

    // Each vector's output must appear three clocks after it is presented.
    task automatic run_vecs(input int n, input string name, output int nirq);
        nirq = 0;
        for (int j = 0; j < n + 2; j++) begin
            if (j < n) {din_startofpacket, din_endofpacket, din_valid, din_data} =
                           {vt[j].sop, vt[j].eop, vt[j].valid, vt[j].pix};
            else {din_startofpacket, din_endofpacket, din_valid, din_data} = '0;
            tick();
            if (frame_irq) nirq++;
            if (j >= 2)
                chk($sformatf("%s[%0d]", name, j - 2),
                    {21'd0, dout_startofpacket, dout_endofpacket, dout_valid,
                     dout_valid ? dout_data : 8'd0},
                    {21'd0, vt[j-2].sop, vt[j-2].eop, vt[j-2].valid,
                     vt[j-2].valid ? vt[j-2].exp : 8'd0});
        end
        {din_startofpacket, din_endofpacket, din_valid, din_data} = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        {av_address, av_read, av_write, av_writedata} = '0;
        {din_startofpacket, din_endofpacket, din_valid, din_data} = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_irq", {31'd0, frame_irq}, 32'd0);
        rd_chk(0, 32'h0, "rst_ctrl");
        rd_chk(1, 32'h0, "rst_low");
        rd_chk(2, 32'h100, "rst_gain");
        rd_chk(3, 32'h0, "rst_minmax");
        rd_chk(4, 32'h0, "rst_sum");
        rd_chk(5, 32'h0, "rst_cnt");
        rd_chk(6, 32'h0, "rst_frames");
        rd_chk(7, 32'h0, "rst_status");

        // 4-pixel frame, passthrough output
        sv(0, 1, 0, 1, 14'd100, 8'd1);
        sv(1, 0, 0, 1, 14'd50, 8'd0);
        sv(2, 0, 0, 1, 14'd400, 8'd6);
        sv(3, 0, 1, 1, 14'd16383, 8'd255);
        run_vecs(4, "stats_out", irqs);
        chk("stats_irq_count", irqs, 1);
        rd_chk(3, 32'h3FFF0032, "stats_minmax");
        rd_chk(4, 32'd16933, "stats_sum");
        rd_chk(5, 32'h4, "stats_cnt");
        rd_chk(6, 32'd1, "stats_frames");
        rd_chk(7, 32'd1, "stats_done");
        wr(7, 32'd1);
        rd_chk(7, 32'd0, "done_cleared");

        // auto black level from previous min (50)
        wr(0, 32'd3);
        sv(0, 1, 0, 1, 14'd300, 8'd250);
        sv(1, 0, 1, 1, 14'd40, 8'd0);
        run_vecs(2, "auto_out", irqs);
        rd_chk(3, 32'h012C0028, "auto_minmax");
        rd_chk(6, 32'd2, "auto_frames");

        // manual black level, gain 2.0 with saturation
        wr(0, 32'd1);
        wr(1, 32'd1000);
        wr(2, 32'h200);
        rd_chk(0, 32'd1, "ctrl_rb");
        rd_chk(1, 32'd1000, "low_rb");
        rd_chk(2, 32'h200, "gain_rb");
        sv(0, 1, 0, 1, 14'd1100, 8'd200);
        sv(1, 0, 0, 0, 14'd0, 8'd0);
        sv(2, 0, 0, 1, 14'd900, 8'd0);
        sv(3, 0, 1, 1, 14'd1200, 8'd255);
        run_vecs(4, "stretch_out", irqs);
        chk("stretch_irq_count", irqs, 1);
        rd_chk(4, 32'd3200, "stretch_sum");

        // passthrough pixels while idle: output but not counted
        wr(0, 32'd0);
        sv(0, 0, 0, 1, 14'h3FC0, 8'hFF);
        sv(1, 0, 0, 1, 14'h0040, 8'h01);
        sv(2, 0, 1, 1, 14'h1000, 8'h40);
        run_vecs(3, "idle_out", irqs);
        chk("idle_irq_count", irqs, 0);
        rd_chk(4, 32'd3200, "idle_sum");
        rd_chk(6, 32'd3, "idle_frames");

        // one-pixel frame
        pix(1, 1, 14'd7);
        chk("one_irq", {31'd0, frame_irq}, 32'd1);
        tick();
        chk("one_irq_clear", {31'd0, frame_irq}, 32'd0);
        rd_chk(3, 32'h00070007, "one_minmax");
        rd_chk(4, 32'd7, "one_sum");
        rd_chk(5, 32'd1, "one_cnt");
        rd_chk(6, 32'd4, "one_frames");

        // sop inside a frame restarts statistics
        pix(1, 0, 14'd10);
        pix(0, 0, 14'd20);
        pix(1, 0, 14'd5);
        pix(0, 1, 14'd6);
        rd_chk(3, 32'h00060005, "restart_minmax");
        rd_chk(4, 32'd11, "restart_sum");
        rd_chk(5, 32'd2, "restart_cnt");
        rd_chk(6, 32'd5, "restart_frames");

        // done set by eop wins over a simultaneous clear
        wr(7, 32'd1);
        pix(1, 0, 14'd1);
        {din_startofpacket, din_endofpacket, din_valid, din_data} = {1'b0, 1'b1, 1'b1, 14'd2};
        {av_address, av_writedata, av_write} = {3'd7, 32'd1, 1'b1};
        tick();
        {din_startofpacket, din_endofpacket, din_valid, din_data} = '0;
        av_write = 1'b0;
        chk("race_irq", {31'd0, frame_irq}, 32'd1);
        rd_chk(7, 32'd1, "race_done");
        rd_chk(6, 32'd6, "race_frames");

        // async reset in the middle of a frame
        pix(1, 0, 14'd100);
        pix(0, 0, 14'd200);
        #2 rst_n = 1'b0;
        #1 chk("arst_dout_valid", {31'd0, dout_valid}, 32'd0);
        repeat (2) tick();
        #3 rst_n = 1'b1;
        tick();
        rd_chk(6, 32'd0, "arst_frames");
        rd_chk(4, 32'd0, "arst_sum");
        rd_chk(2, 32'h100, "arst_gain");
        rd_chk(7, 32'd0, "arst_done");
        pix(0, 1, 14'd50);
        rd_chk(6, 32'd0, "arst_idle_eop");
        pix(1, 0, 14'd8);
        pix(0, 1, 14'd9);
        rd_chk(3, 32'h00090008, "post_minmax");
        rd_chk(4, 32'd17, "post_sum");
        rd_chk(5, 32'd2, "post_cnt");
        rd_chk(6, 32'd1, "post_frames");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/detector_agc_stretch.md
Name: detector_agc_stretch

Overview:
- Downstream consumer of the detector driver's 14-bit video stream, in the same clock domain as that stream.
- Gathers per-frame statistics: min, max, pixel sum, pixel count, frame counter.
- Maps each 14-bit pixel to 8 bits with a linear stretch: subtract a black level, multiply by a gain, saturate.
- Software reads the statistics and sets the gain over a small Avalon-MM register slave.

Parameters:
- GAIN_SHIFT, 8, right shift applied to (diff*gain); 8 makes gain a Q8.8 value.
- SUM_W, 40, width of the pixel-sum accumulator.
- CNT_W, 24, width of the per-frame pixel counter.

Ports:
- clk  in  1  stream and register clock.
- rst_n  in  1  asynchronous active-low reset.
- av_address  in  3  register address.
- av_read  in  1  read strobe.
- av_readdata  out  32  read data, valid 1 cycle after av_read.
- av_write  in  1  write strobe.
- av_writedata  in  32  write data.
- din_startofpacket  in  1  first pixel of frame.
- din_endofpacket  in  1  last pixel of frame.
- din_valid  in  1  pixel qualifier; there is no backpressure.
- din_data  in  14  pixel.
- dout_startofpacket  out  1  delayed sop.
- dout_endofpacket  out  1  delayed eop.
- dout_valid  out  1  delayed valid.
- dout_data  out  8  stretched pixel.
- frame_irq  out  1  one-cycle pulse on each completed frame.

Behaviour:
- Reset:
  - All outputs 0; av_readdata 0.
  - ctrl=0, manual_low=0, gain=16'h0100.
  - Accumulators, results and frame counter 0; in_frame=0.
- Register map (write at addr / read at addr):
  - 0 ctrl: [0] stretch_en, [1] auto_low (1 = use last frame min as black level).
  - 1 manual_low [13:0].
  - 2 gain [15:0].
  - 3 RO {2'b0,max[13:0],2'b0,min[13:0]}.
  - 4 RO sum[31:0].
  - 5 RO {sum[39:32], count[23:0]} (SUM_W=40, CNT_W=24).
  - 6 RO frame counter [31:0], wraps.
  - 7 status: [0] done sticky; writing 1 clears it.
  - Unmapped reads return 0.
- Frame state machine, two states: IDLE and IN_FRAME.
  - valid&sop (either state): reload accumulators with the current pixel (min=max=sum=pix, count=1), then go to IN_FRAME. A sop inside a frame restarts the frame and discards the partial statistics.
  - valid in IN_FRAME without sop: min/max compare, sum+=pix, count+=1.
  - count saturates at all-ones; sum wraps modulo 2^SUM_W.
  - valid&eop in IN_FRAME, or sop&eop together (one-pixel frame): on the next clock, results ← accumulators including this pixel; frame_cnt+1; done=1; frame_irq=1 for 1 cycle; state → IDLE.
  - valid pixels while IDLE without sop: excluded from statistics, still passed to the output.
  - eop while IDLE: ignored for statistics.
- Simultaneous done set (eop) and software clear of done: set wins.
- Result registers change only on frame completion, so a read never sees a partial frame.
- Datapath, 3-stage pipeline; dout_* are din_* delayed exactly 3 cycles, including when valid=0.
  - S1: low = auto_low ? result_min : manual_low. The low value is sampled once per frame at the valid&sop pixel and held to the end of the frame. diff = pix − low; if negative, diff=0.
  - S2: prod = diff(14b) × gain(16b), 30 bits unsigned.
  - S3: v = prod >> GAIN_SHIFT; dout_data = (v>255) ? 255 : v[7:0].
  - stretch_en=0: dout_data = din_data[13:6], same 3-cycle latency.
  - ctrl and gain writes take effect on the first pixel entering S1 after the write; manual_low is picked up at the next sop.
- Reset mid-frame: everything returns to reset values and the first post-reset frame starts at the next sop.

Test Plan:
- Reset defaults: apply reset, read addrs 0–7 → 0, 0, 0x100, 0, 0, 0, 0, 0; dout_valid=0 and frame_irq=0.
- 4-pixel frame, pixels 100, 50, 400, 16383 with sop on the first and eop on the last.
  - Addr 3 reads 0x3FFF0032.
  - Addr 4 reads 16933.
  - Addr 5 reads 0x00000004.
  - Addr 6 reads 1.
  - frame_irq pulses once; status reads 1; writing 1 to addr 7 clears it.
- Stretch: stretch_en=1, auto_low=0, manual_low=1000, gain=0x0200.
  - pix 1100 → 200.
  - pix 900 → 0.
  - pix 1200 → 255 (saturated).
  - dout_sop/eop/valid each appear exactly 3 cycles after the input.
- Auto low: second frame after a frame with min=50, auto_low=1, gain=0x0100; pix 300 → 250.
- Boundary cases:
  - One-pixel frame (sop=eop=1, pix 7) → min=max=sum=7, count=1.
  - sop mid-frame discards the earlier pixels.
  - Pixels while IDLE are output but not counted.
  - Async reset during a frame → counters 0 and the next frame is counted from its sop.
- Passthrough: stretch_en=0, pix 0x3FC0 → dout_data 0xFF; pix 0x0040 → 0x01.
